// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared encodings for the Game-of-Life seeder and stepper
package life_pkg;

    localparam int ROW_W = 8;

    typedef logic [ROW_W-1:0] row_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_LAST,
        ST_LOAD_FIRST,
        ST_FETCH,
        ST_COMMIT
    } step_state_t;

    typedef enum logic [1:0] {
        SEED_IDLE,
        SEED_FILL,
        SEED_DONE
    } seed_state_t;

endpackage

// File: rtl/life_rule_row.sv
// rtl/life_rule_row.sv - combinational Life rule for one row from its three-row window
module life_rule_row #(
    parameter int W    = 10,
    parameter int WRAP = 1
) (
    input  logic [W-1:0] prev_row,
    input  logic [W-1:0] cur_row,
    input  logic [W-1:0] next_row,
    output logic [W-1:0] new_row
);

    // Rows padded by one column each side so every cell sees ext[c..c+2].
    logic [W+1:0] prev_ext;
    logic [W+1:0] cur_ext;
    logic [W+1:0] next_ext;
    logic [3:0]   n;

    function automatic logic [W+1:0] extend(input logic [W-1:0] row);
        extend = {((WRAP != 0) ? row[0] : 1'b0), row, ((WRAP != 0) ? row[W-1] : 1'b0)};
    endfunction

    assign prev_ext = extend(prev_row);
    assign cur_ext  = extend(cur_row);
    assign next_ext = extend(next_row);

    always_comb begin
        new_row = '0;
        n       = '0;
        for (int c = 0; c < W; c++) begin
            n = 4'(prev_ext[c]) + 4'(prev_ext[c+1]) + 4'(prev_ext[c+2])
              + 4'(cur_ext[c])                      + 4'(cur_ext[c+2])
              + 4'(next_ext[c]) + 4'(next_ext[c+1]) + 4'(next_ext[c+2]);
            new_row[c] = (n == 4'd3) || (cur_row[c] && (n == 4'd2));
        end
    end

endmodule

// File: rtl/life_stepper.sv
// rtl/life_stepper.sv - one in-place Life generation over the arena using a 3-row window
module life_stepper
    import life_pkg::*;
#(
    parameter int ARENA_WIDTH  = 10,
    parameter int ARENA_HEIGHT = 10,
    parameter int WRAP         = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   ready,
    output logic                   done,
    output logic                   changed,
    output logic                   extinct,
    output logic [ROW_W-1:0]       arena_row_select,
    input  logic [ARENA_WIDTH-1:0] arena_columns_cur,
    output logic [ARENA_WIDTH-1:0] arena_columns_new,
    output logic                   arena_columns_write
);

    localparam row_idx_t LAST_ROW = row_idx_t'(ARENA_HEIGHT - 1);

    step_state_t            state;
    step_state_t            state_nxt;
    logic [ARENA_WIDTH-1:0] prev_row;
    logic [ARENA_WIDTH-1:0] cur_row;
    logic [ARENA_WIDTH-1:0] next_row;
    logic [ARENA_WIDTH-1:0] first_row;
    logic [ARENA_WIDTH-1:0] rule_row;
    row_idx_t               r;
    logic                   acc_changed;
    logic                   acc_extinct;
    logic                   last;

    assign last  = (r == LAST_ROW);
    assign ready = (state == ST_IDLE);

    life_rule_row #(
        .W    (ARENA_WIDTH),
        .WRAP (WRAP)
    ) u_rule (
        .prev_row (prev_row),
        .cur_row  (cur_row),
        .next_row (next_row),
        .new_row  (rule_row)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        arena_row_select    = '0;
        arena_columns_new   = '0;
        arena_columns_write = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LOAD_LAST;
            end
            ST_LOAD_LAST: begin
                arena_row_select = LAST_ROW;
                state_nxt        = ST_LOAD_FIRST;
            end
            ST_LOAD_FIRST: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                arena_row_select = last ? r : r + 8'd1;
                state_nxt        = ST_COMMIT;
            end
            ST_COMMIT: begin
                arena_row_select    = r;
                arena_columns_new   = rule_row;
                arena_columns_write = 1'b1;
                state_nxt           = last ? ST_IDLE : ST_FETCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Row r is overwritten only after row r+1 was captured; original row 0 lives in first_row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_row    <= '0;
            cur_row     <= '0;
            next_row    <= '0;
            first_row   <= '0;
            r           <= '0;
            done        <= 1'b0;
            changed     <= 1'b0;
            extinct     <= 1'b0;
            acc_changed <= 1'b0;
            acc_extinct <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        changed     <= 1'b0;
                        extinct     <= 1'b0;
                        acc_changed <= 1'b0;
                        acc_extinct <= 1'b1;
                    end
                end
                ST_LOAD_LAST: begin
                    prev_row <= (WRAP != 0) ? arena_columns_cur : '0;
                end
                ST_LOAD_FIRST: begin
                    cur_row   <= arena_columns_cur;
                    first_row <= arena_columns_cur;
                    r         <= '0;
                end
                ST_FETCH: begin
                    if (last) next_row <= (WRAP != 0) ? first_row : '0;
                    else      next_row <= arena_columns_cur;
                end
                ST_COMMIT: begin
                    acc_changed <= acc_changed | (rule_row != cur_row);
                    acc_extinct <= acc_extinct & (rule_row == '0);
                    prev_row    <= cur_row;
                    cur_row     <= next_row;
                    if (last) begin
                        done    <= 1'b1;
                        changed <= acc_changed | (rule_row != cur_row);
                        extinct <= acc_extinct & (rule_row == '0);
                    end else begin
                        r <= r + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_life_stepper.sv
// tb/tb_life_stepper.sv - randomized and directed bench against a grid-level Life model
module tb_life_stepper;

    typedef logic [9:0] grid_t [10];

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;

    logic       ready1, done1, changed1, extinct1, write1;
    logic [7:0] sel1;
    logic [9:0] new1, cur1;
    logic       ready0, done0, changed0, extinct0, write0;
    logic [7:0] sel0;
    logic [9:0] new0, cur0;

    grid_t arena1, arena0, g1, g0, seed_grid;
    logic  seed_we = 1'b0;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    longint wr_cnt   = 0;
    longint wr_sum   = 0;

    always #5 clk = ~clk;

    assign cur1 = (sel1 < 8'd10) ? arena1[sel1[3:0]] : 10'h000;
    assign cur0 = (sel0 < 8'd10) ? arena0[sel0[3:0]] : 10'h000;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (write1 && sel1 < 8'd10) begin
            arena1[sel1[3:0]] <= new1;
            wr_cnt <= wr_cnt + 1;
            wr_sum <= wr_sum + cyc + 1;
        end else if (seed_we) begin
            arena1 <= seed_grid;
        end
        if (write0 && sel0 < 8'd10) arena0[sel0[3:0]] <= new0;
        else if (seed_we)           arena0 <= seed_grid;
    end

    life_stepper #(.ARENA_WIDTH(10), .ARENA_HEIGHT(10), .WRAP(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .ready(ready1), .done(done1),
        .changed(changed1), .extinct(extinct1), .arena_row_select(sel1),
        .arena_columns_cur(cur1), .arena_columns_new(new1), .arena_columns_write(write1)
    );

    life_stepper #(.ARENA_WIDTH(10), .ARENA_HEIGHT(10), .WRAP(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .ready(ready0), .done(done0),
        .changed(changed0), .extinct(extinct0), .arena_row_select(sel0),
        .arena_columns_cur(cur0), .arena_columns_new(new0), .arena_columns_write(write0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic grid_t life_next(input grid_t g, input bit wrap);
        grid_t res;
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr, cc;
                        rr = r + dr;
                        cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrap) begin
                            rr = (rr + 10) % 10;
                            cc = (cc + 10) % 10;
                        end else if (rr < 0 || rr > 9 || cc < 0 || cc > 9) begin
                            continue;
                        end
                        n += int'(g[rr][cc]);
                    end
                end
                res[r][c] = (n == 3) || (g[r][c] && n == 2);
            end
        end
        return res;
    endfunction

    task automatic seed(input grid_t s);
        @(negedge clk);
        seed_grid = s;
        seed_we   = 1'b1;
        @(negedge clk);
        seed_we = 1'b0;
        g1 = s;
        g0 = s;
    endtask

    task automatic run_gen(input bit poke);
        grid_t  e1, e0;
        bit     ch1, ch0, ex1, ex0, got;
        longint w0, s0, c0, lat;
        e1 = life_next(g1, 1'b1);
        e0 = life_next(g0, 1'b0);
        ch1 = 0; ch0 = 0; ex1 = 1; ex0 = 1;
        for (int i = 0; i < 10; i++) begin
            if (e1[i] != g1[i]) ch1 = 1;
            if (e0[i] != g0[i]) ch0 = 1;
            if (e1[i] != 0)     ex1 = 0;
            if (e0[i] != 0)     ex0 = 0;
        end
        w0 = wr_cnt;
        s0 = wr_sum;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0  = cyc;
        got = 0;
        lat = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (poke) start = (k == 3);
            if (done1) begin
                got = 1;
                lat = cyc - c0;
                check("done_wrap0_same_cycle", done0, 1'b1);
                check("ready_at_done", ready1, 1'b1);
                check("changed_w1", changed1, ch1);
                check("extinct_w1", extinct1, ex1);
                check("changed_w0", changed0, ch0);
                check("extinct_w0", extinct0, ex0);
            end
        end
        start = 1'b0;
        check("done_seen", got, 1'b1);
        check("done_latency", lat, 22);
        check("write_edges_sum", wr_sum - s0, 10 * c0 + 130);
        @(negedge clk);
        check("done_pulse_width", done1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("idle_after_gen", ready1, 1'b1);
        check("write_count", wr_cnt - w0, 10);
        g1 = e1;
        g0 = e0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("arena_w1_row%0d", i), arena1[i], g1[i]);
            check($sformatf("arena_w0_row%0d", i), arena0[i], g0[i]);
        end
    endtask

    initial begin
        grid_t  s, glider;
        longint c0;
        #1;
        check("rst_ready", ready1, 1'b1);
        check("rst_done", done1, 1'b0);
        check("rst_changed", changed1, 1'b0);
        check("rst_extinct", extinct1, 1'b0);
        check("rst_row_select", sel1, 8'd0);
        check("rst_columns_new", new1, 10'h000);
        check("rst_write", write1, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        s = '{default: 10'h000};
        s[4] = 10'h010; s[5] = 10'h010; s[6] = 10'h010;
        seed(s);
        run_gen(1'b0);
        check("blinker_row5", arena1[5], 10'h038);
        check("blinker_row4", arena1[4], 10'h000);
        check("blinker_changed", changed1, 1'b1);
        check("blinker_extinct", extinct1, 1'b0);

        s = '{default: 10'h000};
        s[3] = 10'h018; s[4] = 10'h018;
        seed(s);
        run_gen(1'b0);
        check("block_changed", changed1, 1'b0);
        check("block_extinct", extinct1, 1'b0);
        check("block_row3", arena1[3], 10'h018);

        s = '{default: 10'h000};
        s[0] = 10'h001;
        seed(s);
        run_gen(1'b0);
        check("single_changed", changed1, 1'b1);
        check("single_extinct", extinct1, 1'b1);
        check("single_row0", arena1[0], 10'h000);

        s = '{default: 10'h000};
        s[4] = 10'h010; s[5] = 10'h010; s[6] = 10'h010;
        seed(s);
        run_gen(1'b1);

        glider = '{default: 10'h000};
        glider[7] = 10'h100; glider[8] = 10'h200; glider[9] = 10'h380;
        seed(glider);
        for (int gnum = 0; gnum < 40; gnum++) run_gen(1'b0);
        for (int i = 0; i < 10; i++) check($sformatf("glider_home_row%0d", i), arena1[i], glider[i]);

        for (int sd = 0; sd < 4; sd++) begin
            for (int i = 0; i < 10; i++) s[i] = 10'($urandom);
            seed(s);
            for (int gnum = 0; gnum < 25; gnum++) run_gen(1'b0);
        end

        for (int i = 0; i < 10; i++) s[i] = 10'($urandom);
        seed(s);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
        while (cyc < c0 + 9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_ready", ready1, 1'b1);
        check("midrst_write", write1, 1'b0);
        @(negedge clk);
        check("midrst_ready_next", ready1, 1'b1);
        check("midrst_write_next", write1, 1'b0);
        check("midrst_changed", changed1, 1'b0);
        check("midrst_extinct", extinct1, 1'b0);
        check("midrst_done", done1, 1'b0);
        reset_n = 1'b1;

        s = '{default: 10'h000};
        s[4] = 10'h010; s[5] = 10'h010; s[6] = 10'h010;
        seed(s);
        run_gen(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
